rst_seq_ctrl: RTL
=================

// Module: rst_seq_ctrl
// PURPOSE
//  Parametrised reset sequencer and run-budget monitor for the openmips_min_sopc platform.
//  - Takes the global rst and releases N_CH staged reset outputs (core, memories, peripherals) at programmed cycle offsets.
//  - Counts run cycles against a budget and flags completion, replacing fixed-delay reset/stop timing.
//  - Optionally adds a progress watchdog that re-runs the reset sequence.
// PARAMETERS
//  N_CH        3    number of staged reset outputs (1..8)
//  HOLD_CYCLES 10   cycles after rst release before rst_out[0] deasserts (>=1)
//  STAGE_GAP   2    cycles between successive channel releases (>=1)
//  RUN_CYCLES  500  run budget in cycles after all_released; 0 = unlimited
//  CNT_W       16   width of counters; RUN_CYCLES, WDT_CYCLES < 2**CNT_W
//  WDT_CYCLES  64   watchdog limit, cycles without progress (used only with RST_SEQ_WDT_EN)
// PORTS
//  clk           in   1      system clock
//  rst           in   1      synchronous reset, active-high (1 = RstEnable)
//  soft_rst_req  in   1      1-cycle request to re-run the full sequence
//  progress      in   1      activity pulse from core (e.g. retired instruction)
//  rst_out       out  N_CH   staged resets, active-high, bit i = channel i
//  all_released  out  1      1 when every rst_out bit is 0
//  run_cnt       out  CNT_W  cycles elapsed in RUN
//  run_done      out  1      sticky, budget reached
//  wdt_fault     out  1      sticky watchdog fault flag
//  state         out  2      FSM state: 0 HOLD, 1 STAGE, 2 RUN, 3 DONE
// BEHAVIOUR
//  - One clock (clk); rst is synchronous, active-high; all flops update on the rising edge of clk.
//  - Reset values: rst_out all 1; all_released 0; run_cnt 0; run_done 0; wdt_fault 0; state HOLD; internal counters 0.
//  - Edge numbering: edge 1 = first rising edge with rst sampled 0.
//  - HOLD: seq_cnt increments each edge.
//    - After edge HOLD_CYCLES, rst_out[0] = 0.
//    - Next state is STAGE, or RUN when N_CH == 1.
//  - STAGE: rst_out[i] = 0 after edge HOLD_CYCLES + i*STAGE_GAP.
//    - Released bits never reassert except by rst, soft reset or watchdog.
//  - all_released = 1 after edge HOLD_CYCLES + (N_CH-1)*STAGE_GAP, in the same cycle the last bit clears.
//    - State enters RUN on that same edge.
//  - RUN: after edge (all_released edge + k), run_cnt = k.
//    - When run_cnt reaches RUN_CYCLES: run_done = 1, state DONE.
//    - run_cnt freezes at RUN_CYCLES.
//    - With RUN_CYCLES = 0: never DONE, and run_cnt saturates at 2**CNT_W-1 (no wrap).
//  - DONE: outputs held; only rst or soft_rst_req leave DONE.
//  - soft_rst_req = 1 in any state: on the next edge the block behaves exactly as after rst, except wdt_fault is kept.
//    - The sequence restarts from edge 1 counting.
//  - Priority: rst > soft_rst_req > watchdog trip > run_done/stage advance on the same edge.
//  - rst mid-STAGE or mid-RUN: all bits reassert on that edge and all counters clear. No partial state survives.
// CONFIGURATION
//  - Macro RST_SEQ_WDT_EN defined:
//    - In RUN, wdt_cnt increments each cycle and clears on any cycle with progress = 1.
//    - When wdt_cnt reaches WDT_CYCLES: wdt_fault = 1 (sticky until rst) and an internal soft reset fires on that edge (same as soft_rst_req).
//    - Watchdog inactive in HOLD, STAGE and DONE; wdt_cnt cleared there.
//  - Macro RST_SEQ_WDT_EN undefined:
//    - No wdt_cnt logic; progress ignored; wdt_fault tied 0.
//    - Ports unchanged.
// TESTING
//  1. Defaults, rst = 1 for 5 cycles then 0 -> rst_out = 111 through edge 9; 110 after edge 10; 100 after edge 12; 000 and all_released = 1 after edge 14; state = RUN.
//  2. Continue from 1 -> run_cnt = 500, run_done = 1, state = DONE after edge 514; run_cnt still 500 after 20 more edges.
//  3. soft_rst_req pulse at run_cnt = 37 -> next edge rst_out = 111, run_cnt = 0, run_done = 0; sequence of test 1 repeats relative to the pulse.
//  4. rst = 1 for 1 cycle right after edge 11 (rst_out = 110) -> rst_out = 111, state HOLD; rst_out[0] releases again 10 edges after rst falls.
//  5. RST_SEQ_WDT_EN, progress held 0 in RUN -> after 64 RUN cycles wdt_fault = 1 and rst_out = 111; with progress pulsed every 10 cycles there is no fault.
//  6. soft_rst_req asserted on the edge where run_cnt would reach 500 -> run_done stays 0, state HOLD; N_CH = 1, HOLD_CYCLES = 1 -> RUN entered after edge 1.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module : rst_seq_ctrl
// Staged reset sequencer with run-cycle budget; optional progress watchdog
// enabled by defining RST_SEQ_WDT_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rst_seq_ctrl #(
  parameter int N_CH        = 3,
  parameter int HOLD_CYCLES = 10,
  parameter int STAGE_GAP   = 2,
  parameter int RUN_CYCLES  = 500,
  parameter int CNT_W       = 16,
  parameter int WDT_CYCLES  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_rst_req,
  input  logic             progress,
  output logic [N_CH-1:0]  rst_out,
  output logic             all_released,
  output logic [CNT_W-1:0] run_cnt,
  output logic             run_done,
  output logic             wdt_fault,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_STAGE = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int               LAST_REL = HOLD_CYCLES + (N_CH - 1) * STAGE_GAP;
  localparam logic [CNT_W-1:0] RUN_LIM  = CNT_W'(RUN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q;
  logic [N_CH-1:0]  rst_out_q;
  logic             all_rel_q;
  logic             run_done_q;
  logic             wdt_fault_q;
  logic [CNT_W-1:0] seq_cnt_q;
  logic [CNT_W-1:0] run_cnt_q;
  logic [CNT_W-1:0] seq_cnt_d;
  logic [CNT_W-1:0] run_cnt_d;
  logic             wdt_trip;

  assign seq_cnt_d = seq_cnt_q + 1'b1;
  // Saturation only matters for the unlimited budget; a finite budget stops first.
  assign run_cnt_d = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + 1'b1;

`ifdef RST_SEQ_WDT_EN
  logic [CNT_W-1:0] wdt_cnt_q;
  logic [CNT_W-1:0] wdt_cnt_d;

  assign wdt_cnt_d = progress ? '0 : wdt_cnt_q + 1'b1;
  assign wdt_trip  = (state_q == S_RUN) && (wdt_cnt_d == CNT_W'(WDT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst || soft_rst_req || wdt_trip || (state_q != S_RUN)) begin
      wdt_cnt_q <= '0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
    end
  end
`else
  logic unused_wdt;
  assign unused_wdt = progress ^ (WDT_CYCLES != 0);
  assign wdt_trip   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || soft_rst_req || wdt_trip) begin
      state_q    <= S_HOLD;
      rst_out_q  <= '1;
      all_rel_q  <= 1'b0;
      seq_cnt_q  <= '0;
      run_cnt_q  <= '0;
      run_done_q <= 1'b0;
      // The fault flag survives soft restarts so the cause stays visible.
      if (rst) begin
        wdt_fault_q <= 1'b0;
      end else if (wdt_trip) begin
        wdt_fault_q <= 1'b1;
      end
    end else begin
      case (state_q)
        S_HOLD, S_STAGE: begin
          seq_cnt_q <= seq_cnt_d;
          for (int i = 0; i < N_CH; i++) begin
            if (int'(seq_cnt_d) >= HOLD_CYCLES + i * STAGE_GAP) begin
              rst_out_q[i] <= 1'b0;
            end
          end
          if (int'(seq_cnt_d) >= LAST_REL) begin
            state_q   <= S_RUN;
            all_rel_q <= 1'b1;
          end else if (int'(seq_cnt_d) >= HOLD_CYCLES) begin
            state_q <= S_STAGE;
          end
        end
        S_RUN: begin
          run_cnt_q <= run_cnt_d;
          if ((RUN_CYCLES != 0) && (run_cnt_d == RUN_LIM)) begin
            run_done_q <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
        end
        default: begin
          state_q <= S_HOLD;
        end
      endcase
    end
  end

  assign rst_out      = rst_out_q;
  assign all_released = all_rel_q;
  assign run_cnt      = run_cnt_q;
  assign run_done     = run_done_q;
  assign wdt_fault    = wdt_fault_q;
  assign state        = state_q;

endmodule

`default_nettype wire
